// File: rtl/mips_pkg.sv
// mips_pkg: shared size codes, responder state encoding and data width
package mips_pkg;
    localparam int DATA_W = 32;
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    typedef enum logic [1:0] {DM_IDLE, DM_WAIT, DM_RESP} dm_state_e;
endpackage

// File: rtl/dm_responder_if.sv
// dm_responder_if: MEM-stage request/response bus between pipeline and data memory
interface dm_responder_if;
    import mips_pkg::*;
    logic              req_valid;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              busy;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              addr_err;
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, busy, rsp_valid, rsp_rdata, addr_err
    );
    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, busy, rsp_valid, rsp_rdata, addr_err
    );
endinterface

// File: rtl/dm_lane_unit.sv
// dm_lane_unit: byte-lane merge for stores and lane select/extend for loads
module dm_lane_unit
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] old_word_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [1:0]        size_i,
    input  logic [1:0]        lane_i,
    input  logic              signed_i,
    output logic [DATA_W-1:0] merged_o,
    output logic              misalign_o,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] byte_merged;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

    // drop the store byte into its lane, keeping the other three lanes
    always_comb begin
        byte_merged = old_word_i;
        byte_merged[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
    end

    assign merged_o = size_i == SZ_WORD ? wdata_i :
                      size_i == SZ_HALF ? (lane_i[1] ? {wdata_i[15:0], old_word_i[15:0]}
                                                     : {old_word_i[31:16], wdata_i[15:0]}) :
                      size_i == SZ_BYTE ? byte_merged : old_word_i;

    // the illegal size code is folded in so the caller sees one "bad access" flag
    assign misalign_o = (size_i == SZ_HALF && lane_i[0]) ||
                        (size_i == SZ_WORD && lane_i != 2'd0) ||
                        size_i == 2'd3;

    assign byte_sel = old_word_i[{lane_i, 3'b000} +: 8];
    assign half_sel = old_word_i[{lane_i[1], 4'b0000} +: 16];
    assign rdata_o  = size_i == SZ_BYTE ? {{24{signed_i & byte_sel[7]}}, byte_sel} :
                      size_i == SZ_HALF ? {{16{signed_i & half_sel[15]}}, half_sel} : old_word_i;
endmodule

// File: rtl/dm_responder.sv
// dm_responder: wait-stated data memory answering MEM-stage loads and stores
module dm_responder
    import mips_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    dm_responder_if.slave   dm
);
    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT    = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    dm_state_e         state_q;
    logic [3:0]        cnt_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              addr_err_q;
    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DEPTH_WORDS-1:0] vld_q;

    logic [31:0]       offset;
    logic [AW-1:0]     idx;
    logic              oor;
    logic              err;
    logic              wr_en;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] load_data;
    logic              misalign;

    assign offset   = addr_q - BASE_ADDR;
    assign idx      = offset[AW+1:2];
    assign oor      = {1'b0, offset} >= LIMIT;
    assign err      = oor | misalign;
    assign wr_en    = state_q == DM_RESP && we_q && !err;
    // a word never written since reset reads as zero, which is what clearing storage means
    assign old_word = vld_q[idx] ? mem_q[idx] : '0;

    dm_lane_unit u_lane (
        .old_word_i (old_word),
        .wdata_i    (wdata_q),
        .size_i     (size_q),
        .lane_i     (offset[1:0]),
        .signed_i   (signed_q),
        .merged_o   (merged),
        .misalign_o (misalign),
        .rdata_o    (load_data)
    );

    assign dm.req_ready = state_q == DM_IDLE && dm.req_valid;
    assign dm.busy      = state_q != DM_IDLE;
    assign dm.rsp_valid = rsp_valid_q;
    assign dm.rsp_rdata = rsp_rdata_q;
    assign dm.addr_err  = addr_err_q;

    // request FSM: latch in IDLE, count wait states, answer from RESP with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= DM_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            size_q      <= '0;
            signed_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            addr_err_q  <= 1'b0;
            case (state_q)
                DM_IDLE: if (dm.req_valid) begin
                    we_q     <= dm.req_we;
                    size_q   <= dm.req_size;
                    signed_q <= dm.req_signed;
                    addr_q   <= dm.req_addr;
                    wdata_q  <= dm.req_wdata;
                    cnt_q    <= CNT_INIT;
                    state_q  <= WAIT_CYCLES > 0 ? DM_WAIT : DM_RESP;
                end
                DM_WAIT: if (cnt_q == 4'd0) state_q <= DM_RESP;
                         else cnt_q <= cnt_q - 4'd1;
                DM_RESP: begin
                    rsp_valid_q <= 1'b1;
                    addr_err_q  <= err;
                    rsp_rdata_q <= (err || we_q) ? '0 : load_data;
                    state_q     <= DM_IDLE;
                end
                default: state_q <= DM_IDLE;
            endcase
        end
    end

    // written-since-reset flags, cleared together on reset
    always_ff @(posedge clk) begin
        if (reset) vld_q <= '0;
        else if (wr_en) vld_q[idx] <= 1'b1;
    end

    // storage array, read-modify-write of the addressed lanes in RESP
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[idx] <= merged;
    end
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed checks of timing, lane handling, errors and reset abort
module tb_dm_responder;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    dm_responder_if a_if ();
    dm_responder_if b_if ();

    dm_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut_a (
        .clk(clk), .reset(reset), .dm(a_if.slave)
    );
    dm_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut_b (
        .clk(clk), .reset(reset), .dm(b_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // one request on dut_a; returns response data, error, latency and busy-cycle count
    task automatic access(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output int busy_n);
        a_if.req_valid  = 1'b1;
        a_if.req_we     = we;
        a_if.req_size   = size;
        a_if.req_signed = sgn;
        a_if.req_addr   = addr;
        a_if.req_wdata  = wdata;
        #1;
        chk("accept", a_if.req_ready, 1);
        lat = 0;
        busy_n = 0;
        do begin
            @(posedge clk);
            #1;
            a_if.req_valid = 1'b0;
            lat++;
            busy_n += int'(a_if.busy);
        end while (!a_if.rsp_valid && lat < 20);
        rdata = a_if.rsp_rdata;
        err   = a_if.addr_err;
    endtask

    task automatic run(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          busy_n;
        access(we, size, sgn, addr, wdata, rdata, err, lat, busy_n);
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_busy"}, busy_n, 3);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_rdata"}, rdata, exp_rdata);
    endtask

    initial begin
        int acc;
        int rsp_seen;
        a_if.req_valid = 0; a_if.req_we = 0; a_if.req_size = 0; a_if.req_signed = 0;
        a_if.req_addr = 0; a_if.req_wdata = 0;
        b_if.req_valid = 0; b_if.req_we = 0; b_if.req_size = SZ_WORD; b_if.req_signed = 0;
        b_if.req_addr = 0; b_if.req_wdata = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", a_if.busy, 0);
        chk("rst_rsp_valid", a_if.rsp_valid, 0);
        chk("rst_rdata", a_if.rsp_rdata, 0);
        chk("rst_addr_err", a_if.addr_err, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // zero-wait handshake: accept every other cycle while req_valid is held
        acc = 0;
        for (int k = 0; k < 7; k++) begin
            b_if.req_valid = acc < 3;
            b_if.req_addr  = 32'(acc * 4);
            #1;
            chk($sformatf("hs_ready%0d", k), b_if.req_ready, (k % 2 == 0 && k < 6) ? 1 : 0);
            chk($sformatf("hs_busy%0d", k), b_if.busy, (k % 2 == 1) ? 1 : 0);
            chk($sformatf("hs_rsp%0d", k), b_if.rsp_valid, (k >= 2 && k % 2 == 0) ? 1 : 0);
            if (b_if.req_ready) acc++;
            @(posedge clk);
            #1;
        end
        b_if.req_valid = 1'b0;

        run("sw10",   1, SZ_WORD, 0, 32'h10, 32'h1234_5678, 32'h0, 0);
        run("lw10",   0, SZ_WORD, 0, 32'h10, 32'h0,         32'h1234_5678, 0);
        run("sb21",   1, SZ_BYTE, 0, 32'h21, 32'hAABB_CC80, 32'h0, 0);
        run("lw20",   0, SZ_WORD, 0, 32'h20, 32'h0,         32'h0000_8000, 0);
        run("lb21",   0, SZ_BYTE, 1, 32'h21, 32'h0,         32'hFFFF_FF80, 0);
        run("lbu21",  0, SZ_BYTE, 0, 32'h21, 32'h0,         32'h0000_0080, 0);
        run("sw30",   1, SZ_WORD, 0, 32'h30, 32'hA5A5_8001, 32'h0, 0);
        run("lh32",   0, SZ_HALF, 1, 32'h32, 32'h0,         32'hFFFF_A5A5, 0);
        run("lhu30",  0, SZ_HALF, 0, 32'h30, 32'h0,         32'h0000_8001, 0);
        run("lb33",   0, SZ_BYTE, 1, 32'h33, 32'h0,         32'hFFFF_FFA5, 0);
        run("lh30",   0, SZ_HALF, 1, 32'h30, 32'h0,         32'hFFFF_8001, 0);
        run("sw40",   1, SZ_WORD, 0, 32'h40, 32'hCAFE_F00D, 32'h0, 0);
        run("sh41",   1, SZ_HALF, 0, 32'h41, 32'h0000_1234, 32'h0, 1);
        run("lw40a",  0, SZ_WORD, 0, 32'h40, 32'h0,         32'hCAFE_F00D, 0);
        run("sh42",   1, SZ_HALF, 0, 32'h42, 32'h1111_BEEF, 32'h0, 0);
        run("lw40b",  0, SZ_WORD, 0, 32'h40, 32'h0,         32'hBEEF_F00D, 0);
        run("lw1000", 0, SZ_WORD, 0, 32'h1000, 32'h0,       32'h0, 1);
        run("lw12",   0, SZ_WORD, 0, 32'h12, 32'h0,         32'h0, 1);
        run("lsz3",   0, 2'd3,    0, 32'h10, 32'h0,         32'h0, 1);
        run("lwtop",  0, SZ_WORD, 0, 32'hFFC, 32'h0,        32'h0, 0);
        run("lwneg",  0, SZ_WORD, 0, 32'hFFFF_FFF0, 32'h0,  32'h0, 1);

        // reset while the store sits in WAIT: nothing is written and no response appears
        a_if.req_valid = 1'b1; a_if.req_we = 1'b1; a_if.req_size = SZ_WORD;
        a_if.req_signed = 1'b0; a_if.req_addr = 32'h8; a_if.req_wdata = 32'hDEAD_BEEF;
        #1;
        chk("rst_mid_accept", a_if.req_ready, 1);
        @(posedge clk);
        #1;
        a_if.req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_mid_busy", a_if.busy, 0);
        chk("rst_mid_rsp", a_if.rsp_valid, 0);
        rsp_seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            rsp_seen += int'(a_if.rsp_valid);
        end
        chk("rst_mid_no_rsp", rsp_seen, 0);
        run("lw8", 0, SZ_WORD, 0, 32'h8, 32'h0, 32'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
